// File: rtl/jk_bank_seq_if.sv
// Command channel into the JK bank sequencer: one command per valid/ready handshake.
interface jk_bank_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_seq.sv
// Sequencer turning set/clear/toggle/load/count/verify commands into registered
// j/k drive patterns for a bank of JK flip-flops, reading the bank's q back.
module jk_bank_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_seq_if.slave     cmd,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wrapped
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_CLR    = 3'd2;
    localparam logic [2:0] OP_TGL    = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNTUP  = 3'd5;
    localparam logic [2:0] OP_CNTDN  = 3'd6;
    localparam logic [2:0] OP_VERIFY = 3'd7;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] j_reg;
    logic [WIDTH-1:0] k_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic             wrapped_reg;
    logic             ready_reg;

    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] dn_mask;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] m_sel;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             wrap_hit;
    logic             accept;

    function automatic logic is_count(input logic [2:0] op);
        return (op == OP_CNTUP) || (op == OP_CNTDN);
    endfunction

    // Ripple-carry/borrow toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            if (gi == 0) begin : g_lsb
                assign up_mask[gi] = 1'b1;
                assign dn_mask[gi] = 1'b1;
            end else begin : g_upper
                assign up_mask[gi] = &q[gi-1:0];
                assign dn_mask[gi] = ~|q[gi-1:0];
            end
        end
    endgenerate

    // In IDLE the pattern comes from the command being accepted; afterwards from the latched copy.
    assign op_sel = (state_reg == IDLE) ? cmd.cmd_op   : op_reg;
    assign m_sel  = (state_reg == IDLE) ? cmd.cmd_data : data_reg;
    assign accept = cmd.cmd_valid && ready_reg;

    always_comb begin
        j_next   = '0;
        k_next   = '0;
        wrap_hit = 1'b0;
        case (op_sel)
            OP_SET:  j_next = m_sel;
            OP_CLR:  k_next = m_sel;
            OP_TGL: begin
                j_next = m_sel;
                k_next = m_sel;
            end
            OP_LOAD: begin
                j_next = m_sel;
                k_next = ~m_sel;
            end
            OP_CNTUP: begin
                j_next   = up_mask;
                k_next   = up_mask;
                wrap_hit = &q;
            end
            OP_CNTDN: begin
                j_next   = dn_mask;
                k_next   = dn_mask;
                wrap_hit = ~|q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            data_reg    <= '0;
            cnt_reg     <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            wrapped_reg <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        op_reg      <= cmd.cmd_op;
                        data_reg    <= cmd.cmd_data;
                        cnt_reg     <= cmd.cmd_count;
                        err_reg     <= 1'b0;
                        wrapped_reg <= 1'b0;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        if (cmd.cmd_op == OP_VERIFY) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= (q != cmd.cmd_data);
                        end else if (is_count(cmd.cmd_op) && (cmd.cmd_count == '0)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= DRIVE;
                            j_reg       <= j_next;
                            k_reg       <= k_next;
                            wrapped_reg <= wrap_hit;
                        end
                    end
                end
                DRIVE: begin
                    state_reg <= SETTLE;
                    j_reg     <= '0;
                    k_reg     <= '0;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                end
                SETTLE: begin
                    if (is_count(op_reg) && (cnt_reg != '0)) begin
                        state_reg   <= DRIVE;
                        j_reg       <= j_next;
                        k_reg       <= k_next;
                        wrapped_reg <= wrapped_reg | wrap_hit;
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready = ready_reg;
    assign j             = j_reg;
    assign k             = k_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign wrapped       = wrapped_reg;
endmodule

// File: tb/tb_jk_bank_seq.sv
// Self-checking bench for jk_bank_seq: behavioural JK bank, per-cycle trace model, directed + random commands.
module tb_jk_bank_seq;
    localparam int W  = 4;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;
    logic         wrapped;

    jk_bank_seq_if #(.WIDTH(W), .CNT_W(CW)) cmd_bus ();

    jk_bank_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_bus),
        .q       (q),
        .j       (j),
        .k       (k),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .wrapped (wrapped)
    );

    always #5 clk = ~clk;

    // The flip-flop bank itself: set, clear, toggle or hold per bit.
    always @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= (j & ~q) | (~k & q);
    end

    typedef struct packed {
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         ready;
        logic         err;
        logic         wrapped;
    } obs_t;

    int     checks = 0;
    int     errors = 0;
    obs_t   exp_q[$];
    logic [W-1:0] mq = '0;
    logic   merr = 1'b0;
    logic   mwr  = 1'b0;
    logic   accept_pending = 1'b0;
    obs_t   e_cur;
    obs_t   a_cur;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Expected per-cycle trace of one accepted command, from the opcode rules and plain arithmetic.
    task automatic build(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] n);
        obs_t e;
        logic [W-1:0] cur, nxt, jd, kd;
        logic wr;
        cur = mq;
        e = '0;
        e.busy = 1'b1;
        if (op == 3'd7) begin
            e.q = cur; e.done = 1'b1; e.err = (cur != d);
            exp_q.push_back(e);
            merr = e.err; mwr = 1'b0;
        end else if ((op == 3'd5 || op == 3'd6) && n == 0) begin
            e.q = cur; e.done = 1'b1;
            exp_q.push_back(e);
            merr = 1'b0; mwr = 1'b0;
        end else if (op == 3'd5 || op == 3'd6) begin
            wr = 1'b0;
            for (int s = 0; s < int'(n); s++) begin
                nxt = (op == 3'd5) ? cur + 1'b1 : cur - 1'b1;
                if ((op == 3'd5 && cur == {W{1'b1}}) || (op == 3'd6 && cur == '0)) wr = 1'b1;
                e.j = cur ^ nxt; e.k = cur ^ nxt; e.q = cur; e.wrapped = wr;
                exp_q.push_back(e);
                e.j = '0; e.k = '0; e.q = nxt;
                exp_q.push_back(e);
                cur = nxt;
            end
            e.done = 1'b1;
            exp_q.push_back(e);
            mq = cur; merr = 1'b0; mwr = wr;
        end else begin
            jd = '0; kd = '0; nxt = cur;
            case (op)
                3'd1: begin jd = d;             nxt = cur | d;  end
                3'd2: begin kd = d;             nxt = cur & ~d; end
                3'd3: begin jd = d; kd = d;     nxt = cur ^ d;  end
                3'd4: begin jd = d; kd = ~d;    nxt = d;        end
                default: ;
            endcase
            e.j = jd; e.k = kd; e.q = cur;
            exp_q.push_back(e);
            e.j = '0; e.k = '0; e.q = nxt;
            exp_q.push_back(e);
            e.done = 1'b1;
            exp_q.push_back(e);
            mq = nxt; merr = 1'b0; mwr = 1'b0;
        end
    endtask

    // Single compare process: one comparison of every output against the model per cycle.
    always @(negedge clk) begin
        a_cur.j = j; a_cur.k = k; a_cur.q = q; a_cur.busy = busy; a_cur.done = done;
        a_cur.ready = cmd_bus.cmd_ready; a_cur.err = err; a_cur.wrapped = wrapped;
        if (!rst) begin
            e_cur = '0;
            exp_q.delete();
            mq = '0; merr = 1'b0; mwr = 1'b0; accept_pending = 1'b0;
            exp_q.push_back('0);
        end else if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
        end else begin
            e_cur = '0;
            e_cur.q = mq; e_cur.ready = 1'b1; e_cur.err = merr; e_cur.wrapped = mwr;
        end
        checks++;
        if (a_cur !== e_cur) begin
            errors++;
            $display("FAIL cycle t=%0t got j=%h k=%h q=%h busy=%b done=%b rdy=%b err=%b wrap=%b expected j=%h k=%h q=%h busy=%b done=%b rdy=%b err=%b wrap=%b",
                     $time, a_cur.j, a_cur.k, a_cur.q, a_cur.busy, a_cur.done, a_cur.ready, a_cur.err, a_cur.wrapped,
                     e_cur.j, e_cur.k, e_cur.q, e_cur.busy, e_cur.done, e_cur.ready, e_cur.err, e_cur.wrapped);
        end
        if (rst && e_cur.ready && cmd_bus.cmd_valid && !accept_pending) begin
            accept_pending = 1'b1;
            build(cmd_bus.cmd_op, cmd_bus.cmd_data, cmd_bus.cmd_count);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] n,
                         output int waited);
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = d;
        cmd_bus.cmd_count = n;
        cmd_bus.cmd_valid = 1'b1;
        waited = 0;
        do begin
            @(posedge clk);
            waited++;
        end while (!accept_pending && waited < 200);
        #1;
        if (!accept_pending) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op=%0d not accepted within %0d cycles", op, waited);
        end
        cmd_bus.cmd_valid = 1'b0;
        accept_pending    = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (c > 0) #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d cycles still pending", exp_q.size());
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] n,
                       output int lat);
        int w;
        issue(op, d, n, w);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        wait_drain();
    endtask

    initial begin
        int lat, w1, w2;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = '0;
        cmd_bus.cmd_data  = '0;
        cmd_bus.cmd_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_bus.cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        chk("rel_ready_before_edge", int'(cmd_bus.cmd_ready), 0);
        @(posedge clk); #1;
        chk("rel_ready", int'(cmd_bus.cmd_ready), 1);

        // LOAD 1010: drive for exactly one cycle, result in SETTLE, done at T+3
        issue(3'd4, 4'b1010, '0, w1);
        chk("load_j", int'(j), 4'b1010);
        chk("load_k", int'(k), 4'b0101);
        @(posedge clk); #1;
        chk("load_j_settle", int'(j), 0);
        chk("load_q_settle", int'(q), 4'b1010);
        @(posedge clk); #1;
        chk("load_done_t3", int'(done), 1);
        wait_drain();
        chk("load_ready_t4", int'(cmd_bus.cmd_ready), 1);

        run(3'd1, 4'b0101, '0, lat); chk("set_q", int'(q), 4'b1111); chk("set_lat", lat, 3);
        run(3'd2, 4'b0011, '0, lat); chk("clr_q", int'(q), 4'b1100);
        run(3'd3, 4'b1001, '0, lat); chk("tgl_q", int'(q), 4'b0101);

        run(3'd4, 4'b1110, '0, lat);
        run(3'd5, '0, 8'd3, lat);
        chk("cntup_lat", lat, 7); chk("cntup_q", int'(q), 4'b0001); chk("cntup_wrap", int'(wrapped), 1);
        run(3'd6, '0, 8'd2, lat);
        chk("cntdn_lat", lat, 5); chk("cntdn_q", int'(q), 4'b1111); chk("cntdn_wrap", int'(wrapped), 1);

        run(3'd4, 4'b0101, '0, lat);
        run(3'd7, 4'b0101, '0, lat); chk("verify_ok_lat", lat, 1); chk("verify_ok_err", int'(err), 0);
        run(3'd7, 4'b0000, '0, lat); chk("verify_bad_lat", lat, 1); chk("verify_bad_err", int'(err), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", int'(err), 1);
        run(3'd5, '0, 8'd0, lat);
        chk("cnt0_lat", lat, 1); chk("cnt0_err_cleared", int'(err), 0); chk("cnt0_q", int'(q), 4'b0101);

        // Second command held valid while the first COUNT is busy
        issue(3'd5, '0, 8'd4, w1);
        issue(3'd1, 4'b0000, '0, w2);
        chk("held_accept_wait", w2, 10);
        wait_drain();

        // Reset during SETTLE of step 2 of a 5-step count
        issue(3'd5, '0, 8'd5, w1);
        repeat (3) @(posedge clk);
        #3;
        chk("mid_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("arst_j", int'(j), 0);
        chk("arst_k", int'(k), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ready", int'(cmd_bus.cmd_ready), 0);
        chk("arst_q", int'(q), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_drain();
        run(3'd5, '0, 8'd1, lat);
        chk("post_rst_lat", lat, 3); chk("post_rst_q", int'(q), 4'b0001);

        // Randomized commands, sometimes back-to-back, sometimes held during busy
        for (int i = 0; i < 60; i++) begin
            logic [2:0]    rop;
            logic [W-1:0]  rd;
            logic [CW-1:0] rn;
            rop = 3'($urandom_range(0, 7));
            rd  = W'($urandom);
            rn  = CW'($urandom_range(0, 4));
            issue(rop, rd, rn, w1);
            case ($urandom_range(0, 2))
                0: wait_drain();
                1: begin
                    wait_drain();
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                end
                default: ;
            endcase
        end
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
